// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, state encoding,
// datapath mux/ALU selects and the bundled control-output record.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_IF     = 4'd1,
    ST_ID     = 4'd2,
    ST_EX_R   = 4'd3,
    ST_EX_I   = 4'd4,
    ST_EX_ADR = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_R   = 4'd8,
    ST_WB_I   = 4'd9,
    ST_WB_LW  = 4'd10,
    ST_BR     = 4'd11,
    ST_JMP    = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_w;
    logic       ir_w;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control unit and its datapath: opcode and
// zero flow into the controller, enables and mux selects flow out.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       PC_W;
  logic       IR_W;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, zero,
    output PC_W, IR_W, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, instr_done, illegal
  );

  modport slave (
    output opcode, zero,
    input  PC_W, IR_W, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decoder: maps the current state (plus opcode and zero
// where a step is instruction-dependent) onto every datapath control.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Per-state control decode; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_INIT: ctrl = '0;
      ST_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_w      = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_w      = 1'b1;
      end
      ST_ID: begin
        ctrl.alu_src_b = ALUSRCB_BRIMM;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        // An unsupported opcode ends the instruction here.
        if (!op_supported(opcode)) begin
          ctrl.instr_done = 1'b1;
        end else begin
          ctrl.instr_done = 1'b0;
        end
      end
      ST_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        if (opcode == OP_ORI) begin
          ctrl.ext_op = 1'b0;
          ctrl.alu_op = ALUOP_OR;
        end else begin
          ctrl.ext_op = 1'b1;
          ctrl.alu_op = ALUOP_ADD;
        end
      end
      ST_EX_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BR: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALUSRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
        if (opcode == OP_BNE) begin
          ctrl.pc_w = ~zero;
        end else begin
          ctrl.pc_w = zero;
        end
      end
      ST_JMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_w       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: state register, next-state sequencing and the
// sticky illegal-opcode flag; output decode lives in mc_ctrl_outdec.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_control_fsm_if.master   bus
);

  state_e state_r;
  logic   illegal_r;
  ctrl_t  ctrl_s;

  // State sequencing and illegal-opcode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_INIT;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: state_r <= ST_IF;
        ST_IF:   state_r <= ST_ID;
        ST_ID: begin
          case (bus.opcode)
            OP_RTYPE:        state_r <= ST_EX_R;
            OP_ADDI, OP_ORI: state_r <= ST_EX_I;
            OP_LW, OP_SW:    state_r <= ST_EX_ADR;
            OP_BEQ, OP_BNE:  state_r <= ST_BR;
            OP_J:            state_r <= ST_JMP;
            default: begin
              state_r   <= ST_IF;
              illegal_r <= 1'b1;
            end
          endcase
        end
        ST_EX_R:   state_r <= ST_WB_R;
        ST_EX_I:   state_r <= ST_WB_I;
        ST_EX_ADR: begin
          if (bus.opcode == OP_LW) begin
            state_r <= ST_MEM_RD;
          end else begin
            state_r <= ST_MEM_WR;
          end
        end
        ST_MEM_RD: state_r <= ST_WB_LW;
        ST_MEM_WR: state_r <= ST_IF;
        ST_WB_R:   state_r <= ST_IF;
        ST_WB_I:   state_r <= ST_IF;
        ST_WB_LW:  state_r <= ST_IF;
        ST_BR:     state_r <= ST_IF;
        ST_JMP:    state_r <= ST_IF;
        default:   state_r <= ST_INIT;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .state  (state_r),
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .ctrl   (ctrl_s)
  );

  assign bus.PC_W       = ctrl_s.pc_w;
  assign bus.IR_W       = ctrl_s.ir_w;
  assign bus.MemRead    = ctrl_s.mem_read;
  assign bus.MemWrite   = ctrl_s.mem_write;
  assign bus.IorD       = ctrl_s.iord;
  assign bus.RegWrite   = ctrl_s.reg_write;
  assign bus.RegDst     = ctrl_s.reg_dst;
  assign bus.MemtoReg   = ctrl_s.mem_to_reg;
  assign bus.ALUSrcA    = ctrl_s.alu_src_a;
  assign bus.ALUSrcB    = ctrl_s.alu_src_b;
  assign bus.ExtOp      = ctrl_s.ext_op;
  assign bus.ALUOp      = ctrl_s.alu_op;
  assign bus.PCSource   = ctrl_s.pc_source;
  assign bus.instr_done = ctrl_s.instr_done;
  assign bus.illegal    = illegal_r;

endmodule
